// File: rtl/hps_reset_pkg.sv
// Shared request indices, FSM state type and small helpers for the HPS reset request generator.
package hps_reset_pkg;

  localparam int REQ_COLD  = 0;
  localparam int REQ_WARM  = 1;
  localparam int REQ_DEBUG = 2;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ISSUE,
    LOCKOUT
  } state_t;

  // Counter width that stays legal when the terminal count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] req_onehot(input int idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low push-button.
module key_debounce
  import hps_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          raw_pressed;

  assign raw_pressed = ~sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      // Count only an unbroken run of disagreement; any agreement restarts it.
      if (raw_pressed == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        pressed <= ~pressed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hps_reset_req_gen.sv
// Classifies debounced KEY0/KEY1 activity into cold, warm or debug HPS reset request levels.
// Chord (debug) detection is built only when HPS_RESET_REQ_DEBUG_EN is defined.
module hps_reset_req_gen
  import hps_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REQ_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  output logic [1:0] debounced_buttons,
  output logic [2:0] reset_req,
  output logic       busy
);

  localparam int            HW         = cnt_w(LONG_CYCLES);
  // HOLD is entered one cycle after the debounced press, so the threshold is one short.
  localparam logic [HW-1:0] LONG_LAST  = HW'((LONG_CYCLES >= 2) ? (LONG_CYCLES - 2) : 0);
  localparam logic [HW-1:0] HOLD_MAX   = '1;
  localparam int            IW         = cnt_w(REQ_CYCLES);
  localparam logic [IW-1:0] ISSUE_LAST = IW'(REQ_CYCLES - 1);

  logic [1:0]    k;
  logic          chord_k1;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] issue_cnt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n[0]),
    .pressed (k[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n[1]),
    .pressed (k[1])
  );

  assign debounced_buttons = k;

`ifdef HPS_RESET_REQ_DEBUG_EN
  assign chord_k1 = k[1];
`else
  assign chord_k1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      issue_cnt <= '0;
      reset_req <= 3'b000;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (k[0] && chord_k1) begin
            state     <= ISSUE;
            reset_req <= req_onehot(REQ_DEBUG);
            issue_cnt <= '0;
            busy      <= 1'b1;
          end else if (k[0]) begin
            state    <= HOLD;
            hold_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
          // Priority debug > cold > warm; cold fires even while KEY0 is still held.
          if (chord_k1) begin
            state     <= ISSUE;
            reset_req <= req_onehot(REQ_DEBUG);
            issue_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state     <= ISSUE;
            reset_req <= req_onehot(REQ_COLD);
            issue_cnt <= '0;
          end else if (!k[0]) begin
            state     <= ISSUE;
            reset_req <= req_onehot(REQ_WARM);
            issue_cnt <= '0;
          end
        end
        ISSUE: begin
          if (issue_cnt == ISSUE_LAST) begin
            state     <= LOCKOUT;
            reset_req <= 3'b000;
          end else begin
            issue_cnt <= issue_cnt + IW'(1);
          end
        end
        LOCKOUT: begin
          // A key still held after a request must be released before anything new.
          if (!k[0] && !chord_k1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          reset_req <= 3'b000;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Directed test-plan scenarios plus random key activity, checked every cycle against a behavioural model.
module tb_hps_reset_req_gen;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REQ  = 3;
`ifdef HPS_RESET_REQ_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic [1:0] debounced_buttons;
  logic [2:0] reset_req;
  logic       busy;

  always #5 clk = ~clk;

  hps_reset_req_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REQ_CYCLES      (REQ)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .key_n             (key_n),
    .debounced_buttons (debounced_buttons),
    .reset_req         (reset_req),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: raw press history, debounced levels, request timing.
  bit         h0[$];
  bit         h1[$];
  bit         m_db0, m_db1;
  bit         m_hold, m_lock;
  int         m_age, m_left;
  logic [2:0] m_req;

  logic [2:0] seen_req, prev_req;
  logic [1:0] seen_db, prev_db;
  bit         seen_busy;
  int         req_cyc, db0_rise, req_rise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // True when the last DEB synchronised samples all disagree with the debounced level.
  function automatic bit stable_opposite(input bit q[$], input bit db);
    for (int i = 0; i < DEB; i++) if (q[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit busy_exp();
    return m_hold || (m_left > 0) || m_lock;
  endfunction

  task automatic issue(input int idx);
    m_hold = 1'b0;
    m_left = REQ;
    m_req  = 3'b001 << idx;
  endtask

  task automatic model_step(input bit r, input bit p0, input bit p1);
    bit k0, k1;
    k0 = m_db0;
    k1 = DBG && m_db1;
    if (!r) begin
      h0.delete();
      h1.delete();
      for (int i = 0; i < DEB + 2; i++) begin
        h0.push_back(1'b0);
        h1.push_back(1'b0);
      end
      m_db0 = 0; m_db1 = 0; m_hold = 0; m_lock = 0; m_age = 0; m_left = 0; m_req = 3'b000;
      return;
    end
    h0.push_back(p0); void'(h0.pop_front());
    h1.push_back(p1); void'(h1.pop_front());
    if (stable_opposite(h0, m_db0)) m_db0 = !m_db0;
    if (stable_opposite(h1, m_db1)) m_db1 = !m_db1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_req  = 3'b000;
        m_lock = 1'b1;
      end
    end else if (m_lock) begin
      if (!k0 && !k1) m_lock = 1'b0;
    end else if (m_hold) begin
      m_age++;
      if (k1) issue(2);
      else if (m_age == LONG) issue(0);
      else if (!k0) issue(1);
    end else if (k0) begin
      if (k1) issue(2);
      else begin
        m_hold = 1'b1;
        m_age  = 1;
      end
    end
  endtask

  task automatic clear_obs();
    seen_req = '0; seen_db = '0; seen_busy = 0; req_cyc = 0; db0_rise = -1; req_rise = -1;
  endtask

  task automatic tick();
    bit r, p0, p1;
    r  = rst_n;
    p0 = !key_n[0];
    p1 = !key_n[1];
    @(posedge clk);
    cyc++;
    model_step(r, p0, p1);
    @(negedge clk);
    chk("dbnc", debounced_buttons, {m_db1, m_db0});
    chk("req", reset_req, m_req);
    chk("busy", busy, busy_exp());
    chk("onehot", $countones(reset_req) <= 1, 1);
    seen_req  |= reset_req;
    seen_db   |= debounced_buttons;
    seen_busy |= busy;
    if (reset_req != 0) req_cyc++;
    if (debounced_buttons[0] && !prev_db[0]) db0_rise = cyc;
    if (reset_req != 0 && prev_req == 0) req_rise = cyc;
    prev_db  = debounced_buttons;
    prev_req = reset_req;
  endtask

  task automatic run(input logic [1:0] k, input int n);
    key_n = k;
    repeat (n) tick();
  endtask

  initial begin
    int fall, budget, n;
    prev_db  = '0;
    prev_req = '0;
    rst_n = 1'b0;
    key_n = 2'b11;
    repeat (3) tick();
    chk("rst_req", reset_req, 3'b000);
    chk("rst_dbnc", debounced_buttons, 2'b00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    run(2'b11, 5);

    // Glitch rejection, then a clean fall
    clear_obs();
    run(2'b10, 3);
    run(2'b11, 12);
    chk("glitch_db", seen_db, 2'b00);
    chk("glitch_req", seen_req, 3'b000);
    clear_obs();
    fall = cyc;
    run(2'b10, 10);
    chk("db_latency", db0_rise - fall, 2 + DEB);
    run(2'b11, 40);

    // Short press -> warm
    clear_obs();
    run(2'b10, 10);
    run(2'b11, 40);
    chk("short_req", seen_req, 3'b010);
    chk("short_len", req_cyc, REQ);
    chk("short_busy", busy, 1'b0);

    // Long press -> cold
    clear_obs();
    run(2'b10, 40);
    chk("long_req", seen_req, 3'b001);
    chk("long_latency", req_rise - db0_rise, LONG);
    run(2'b11, 40);
    chk("long_len", req_cyc, REQ);
    chk("long_busy", busy, 1'b0);

    // Chord
    clear_obs();
    run(2'b10, 5);
    run(2'b00, 30);
    run(2'b11, 40);
    chk("chord_req", seen_req, DBG ? 3'b100 : 3'b001);
    chk("chord_len", req_cyc, REQ);

    // Reset on the second request cycle
    clear_obs();
    key_n  = 2'b10;
    budget = 0;
    while (reset_req == 3'b000 && budget < 200) begin
      tick();
      budget++;
    end
    chk("midrst_reached", budget < 200, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_req", reset_req, 3'b000);
    chk("midrst_dbnc", debounced_buttons, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    clear_obs();
    run(2'b10, 8);
    run(2'b11, 40);
    chk("midrst_new_req", seen_req, 3'b010);
    chk("midrst_new_len", req_cyc, REQ);

    // KEY1 alone
    clear_obs();
    run(2'b01, 50);
    run(2'b11, 20);
    chk("k1_req", seen_req, 3'b000);
    chk("k1_busy", seen_busy, 1'b0);

    // Random key activity with occasional resets
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end
      n = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 0) run(2'b11, n);
      else run(2'($urandom_range(0, 3)), n);
    end
    run(2'b11, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
